fetch_prefetch: RTL
===================

// Module: fetch_prefetch
// PURPOSE
//  Parametrised instruction-fetch front end; next generation of the single-PC fetch stage.
//  Owns the PC and issues sequential requests to instruction memory over a valid/ready bus.
//  Holds up to DEPTH outstanding/buffered words and delivers {pc,instr} to decode over a
//  valid/ready stream. Redirects (branch/jump) flush the buffer and discard stale responses.
// PARAMETERS
//  XLEN      32        address/PC width
//  ILEN      32        instruction word width
//  DEPTH     4         prefetch queue depth, power of 2, >=2; also max in-flight+buffered words
//  RESET_PC  32'h0     PC loaded on reset
// PORTS
//  clk              in   1      clock, rising edge
//  rst_n            in   1      asynchronous active-low reset
//  redirect_valid   in   1      branch taken / redirect request this cycle
//  redirect_target  in   XLEN   new fetch PC
//  imem_req_valid   out  1      fetch request valid
//  imem_req_ready   in   1      memory accepts request
//  imem_req_addr    out  XLEN   request address (word-aligned)
//  imem_rsp_valid   in   1      response data valid; in order, >=1 cycle after accept, no backpressure
//  imem_rsp_data    in   ILEN   response instruction word
//  instr_valid      out  1      decode-side entry valid (queue head)
//  instr_ready      in   1      decode consumes head
//  instr_pc         out  XLEN   PC of head entry
//  instr_data       out  ILEN   instruction of head entry
//  fetch_misaligned out  1      (FETCH_MISALIGN_EN only) sticky misaligned-target flag
// BEHAVIOUR
//  Reset: pc=RESET_PC, rsp_pc=RESET_PC, outstanding=0, drop_cnt=0, queue empty, running=0;
//   imem_req_valid=0, instr_valid=0, fetch_misaligned=0. running sets on first edge after release.
//  Issue: imem_req_valid = running & !redirect_valid & (outstanding + q_count < DEPTH) [& !halted].
//   imem_req_addr = pc. On req handshake: pc += 4, outstanding += 1. Addr held stable while stalled.
//  Response: each imem_rsp_valid decrements outstanding. If drop_cnt>0: discard, drop_cnt -= 1.
//   Else push {rsp_pc, imem_rsp_data} into queue, rsp_pc += 4. Credit rule guarantees no overflow.
//  Drain: instr_valid = !q_empty; pop on instr_valid & instr_ready. Combinational head outputs.
//  Redirect (priority over everything): same cycle -> no request issued, queue flushed (pop ignored),
//   pc <= target, rsp_pc <= target, drop_cnt <= outstanding - rsp_valid (response in this cycle
//   is discarded too). Fetch at target issues next cycle. Back-to-back redirects: last one wins.
//  Simultaneous req handshake + response: outstanding unchanged. Push + pop same cycle: count unchanged.
//  PC arithmetic modulo 2^XLEN; wrap at 0xFFFF_FFFC -> 0 silently.
//  Latency: redirect -> first instr_valid at target = 1 + memory latency + 1 cycles minimum.
//  Reset mid-operation: all state returns to reset values asynchronously; late responses after
//   release are illegal (memory also reset).
// CONFIGURATION
//  FETCH_MISALIGN_EN defined: redirect_target[1:0]!=0 sets fetch_misaligned and halted; no requests
//   issue until next aligned redirect, which clears both. Queue/in-flight handling unchanged.
//  Not defined: port absent; target[1:0] forced to 2'b00 on load.
// STRUCTURE
//  fetch_pkg: fetch_entry_t {pc, instr} packed struct, ILEN/XLEN defaults, PC_STEP=4 constant.
//  Sub-module fetch_fifo: sync FIFO of fetch_entry_t, DEPTH entries, push/pop/flush, count/empty/full.
//  Top holds pc, rsp_pc, outstanding, drop_cnt (width $clog2(DEPTH+1)), running, halted.
// TESTING
//  1 Reset, mem ready=1, latency 1, instr_ready=1 -> req addrs 0,4,8,..; instr_pc 0,4,8 in order.
//  2 instr_ready=0 from start -> exactly 4 requests issued, queue full, req_valid low, addr=0x10 held.
//  3 2 in flight, redirect to 0x20 -> both responses dropped; next instr_pc=0x20, then 0x24.
//  4 redirect same cycle as response and pop -> queue empty next cycle, response discarded.
//  5 imem_req_ready toggling 1/0 -> no skipped/duplicated addresses, data order matches PCs.
//  6 FETCH_MISALIGN_EN, redirect 0x22 -> fetch_misaligned=1, no requests; redirect 0x40 clears, resumes.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Latency: n/a (types only).
// Backpressure: n/a.
package fetch_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned ILEN_DEF = 32;

    // Byte distance between consecutive instruction words
    localparam logic [XLEN_DEF-1:0] PC_STEP = 32'd4;

    // One buffered fetch result as presented to decode
    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [ILEN_DEF-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with single-cycle flush.
// Latency: a pushed entry is visible at the head on the following cycle.
// Backpressure: none internally; the caller must not push when full or pop when empty.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  fetch_entry_t  push_dat_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output fetch_entry_t  head_o,
    output logic [CW-1:0] count_o,
    output logic          empty_o,
    output logic          full_o
);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;

    // Pointer and occupancy bookkeeping; flush wins over push/pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    // Storage array; data needs no reset since occupancy gates visibility
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/fetch_prefetch.sv
// Instruction-fetch front end: owns the PC, prefetches sequential words, streams {pc,instr} to decode.
// Latency: redirect -> first instr_valid at target = 1 + memory latency + 1 cycles minimum.
// Backpressure: requests stop once in-flight plus buffered words reach DEPTH; optional FETCH_MISALIGN_EN halts on misaligned targets.
module fetch_prefetch
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = XLEN_DEF,
    parameter int unsigned     ILEN     = ILEN_DEF,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr_pc,
    output logic [ILEN-1:0] instr_data
`ifdef FETCH_MISALIGN_EN
    ,
    output logic            fetch_misaligned
`endif
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] pc_q, pc_d, rsp_pc_q, rsp_pc_d, target_ld;
    logic [CW-1:0]   outstanding_q, outstanding_d, drop_cnt_q, drop_cnt_d, q_count;
    logic            running_q, halted, credit_ok, req_fire, rsp_drop, push, pop, q_empty, q_full;
    fetch_entry_t    push_entry, head;

`ifdef FETCH_MISALIGN_EN
    logic halted_q;

    // Misaligned redirect halts issue until an aligned redirect arrives
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              halted_q <= 1'b0;
        else if (redirect_valid) halted_q <= (redirect_target[1:0] != 2'b00);
    end

    assign halted           = halted_q;
    assign fetch_misaligned = halted_q;
    assign target_ld        = redirect_target;
`else
    assign halted    = 1'b0;
    assign target_ld = redirect_target & ~XLEN'(3);
`endif

    // Words already requested plus words buffered may never exceed the queue size
    assign credit_ok      = ({1'b0, outstanding_q} + {1'b0, q_count}) < (CW + 1)'(DEPTH);
    assign imem_req_valid = running_q && !redirect_valid && credit_ok && !halted;
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Responses owed to a flushed path are swallowed until drop_cnt reaches zero
    assign rsp_drop = imem_rsp_valid && (drop_cnt_q != '0);
    assign push     = imem_rsp_valid && (drop_cnt_q == '0) && !redirect_valid && !q_full;
    assign pop      = instr_valid && instr_ready && !redirect_valid;

    assign push_entry.pc    = rsp_pc_q;
    assign push_entry.instr = imem_rsp_data;

    // Next-state for PCs and counters; redirect overrides normal progress
    always_comb begin
        pc_d          = pc_q;
        rsp_pc_d      = rsp_pc_q;
        drop_cnt_d    = drop_cnt_q;
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);
        if (redirect_valid) begin
            pc_d       = target_ld;
            rsp_pc_d   = target_ld;
            drop_cnt_d = outstanding_q - CW'(imem_rsp_valid);
        end else begin
            if (req_fire) pc_d = pc_q + XLEN'(PC_STEP);
            if (rsp_drop) drop_cnt_d = drop_cnt_q - CW'(1);
            if (push)     rsp_pc_d = rsp_pc_q + XLEN'(PC_STEP);
        end
    end

    // Fetch state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            running_q     <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            running_q     <= 1'b1;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (push),
        .push_dat_i (push_entry),
        .pop_i      (pop),
        .flush_i    (redirect_valid),
        .head_o     (head),
        .count_o    (q_count),
        .empty_o    (q_empty),
        .full_o     (q_full)
    );

    assign instr_valid = !q_empty;
    assign instr_pc    = head.pc;
    assign instr_data  = head.instr;

endmodule
